// File: rtl/maveric_csr_pkg.sv
// Shared CSR indices, trap cause codes and trap sequencer enums.
package maveric_csr_pkg;

    localparam int unsigned CSR_MSTATUS = 0;
    localparam int unsigned CSR_MIE     = 2;
    localparam int unsigned CSR_MTVEC   = 3;
    localparam int unsigned CSR_MCAUSE  = 4;
    localparam int unsigned CSR_MEPC    = 5;
    localparam int unsigned CSR_MIP     = 6;

    localparam int unsigned CAUSE_W   = 4;
    localparam logic [3:0]  CAUSE_MSI = 4'd3;
    localparam logic [3:0]  CAUSE_MTI = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP_RD,
        ST_TRAP_WR,
        ST_RET_RD,
        ST_REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_EXC,
        KIND_INT,
        KIND_RET
    } trap_kind_t;

endpackage

// File: rtl/trap_controller_if.sv
// CSR port bundle between the trap sequencer (master) and csr_file (slave).
interface trap_controller_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) ();
    logic                  o_csr_own;
    logic [ADDR_WIDTH-1:0] o_csr_read_addr;
    logic                  o_csr_writable;
    logic                  o_csr_we_1;
    logic                  o_csr_we_2;
    logic [ADDR_WIDTH-1:0] o_csr_waddr_1;
    logic [ADDR_WIDTH-1:0] o_csr_waddr_2;
    logic [DATA_WIDTH-1:0] o_csr_wdata_1;
    logic [DATA_WIDTH-1:0] o_csr_wdata_2;
    logic                  o_interrupt_jump;
    logic                  o_mret_instr;
    logic [DATA_WIDTH-1:0] i_csr_read_data;

    modport master (
        output o_csr_own, o_csr_read_addr, o_csr_writable,
               o_csr_we_1, o_csr_we_2, o_csr_waddr_1, o_csr_waddr_2,
               o_csr_wdata_1, o_csr_wdata_2, o_interrupt_jump, o_mret_instr,
        input  i_csr_read_data
    );

    modport slave (
        input  o_csr_own, o_csr_read_addr, o_csr_writable,
               o_csr_we_1, o_csr_we_2, o_csr_waddr_1, o_csr_waddr_2,
               o_csr_wdata_1, o_csr_wdata_2, o_interrupt_jump, o_mret_instr,
        output i_csr_read_data
    );
endinterface

// File: rtl/trap_prio_enc.sv
// Boundary arbitration: exception > software irq > timer irq > mret.
module trap_prio_enc
    import maveric_csr_pkg::*;
(
    input  logic         i_boundary,
    input  logic         i_exc_req,
    input  logic [3:0]   i_exc_cause,
    input  logic         i_mret,
    input  logic         i_mie_mstatus,
    input  logic         i_mtip_mip,
    input  logic         i_msip_mip,
    input  logic         i_mtie_mie,
    input  logic         i_msie_mie,
    output logic         o_accept_c,
    output trap_kind_t   o_kind_c,
    output logic [3:0]   o_cause_c
);
    logic sw_pend;
    logic tm_pend;

    always_comb begin
        sw_pend   = i_mie_mstatus & i_msip_mip & i_msie_mie;
        tm_pend   = i_mie_mstatus & i_mtip_mip & i_mtie_mie;
        o_kind_c  = KIND_NONE;
        o_cause_c = 4'd0;
        if (i_exc_req) begin
            o_kind_c  = KIND_EXC;
            o_cause_c = i_exc_cause;
        end else if (sw_pend) begin
            o_kind_c  = KIND_INT;
            o_cause_c = CAUSE_MSI;
        end else if (tm_pend) begin
            o_kind_c  = KIND_INT;
            o_cause_c = CAUSE_MTI;
        end else if (i_mret) begin
            o_kind_c  = KIND_RET;
        end
        o_accept_c = i_boundary & (o_kind_c != KIND_NONE);
    end
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates traps/mret at instruction boundaries,
// sequences the csr_file accesses and strobes a redirect PC to fetch.
module trap_controller
    import maveric_csr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_boundary,
    input  logic                  i_exc_req,
    input  logic [3:0]            i_exc_cause,
    input  logic                  i_mret,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_mie_mstatus,
    input  logic                  i_mtip_mip,
    input  logic                  i_msip_mip,
    input  logic                  i_mtie_mie,
    input  logic                  i_msie_mie,
    trap_controller_if.master     csr,
    output logic                  o_busy,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc
);
    logic       accept_c;
    trap_kind_t kind_c;
    logic [3:0] cause_c;

    trap_prio_enc u_prio (
        .i_boundary    (i_boundary),
        .i_exc_req     (i_exc_req),
        .i_exc_cause   (i_exc_cause),
        .i_mret        (i_mret),
        .i_mie_mstatus (i_mie_mstatus),
        .i_mtip_mip    (i_mtip_mip),
        .i_msip_mip    (i_msip_mip),
        .i_mtie_mie    (i_mtie_mie),
        .i_msie_mie    (i_msie_mie),
        .o_accept_c    (accept_c),
        .o_kind_c      (kind_c),
        .o_cause_c     (cause_c)
    );

    trap_state_t           state_q,  state_d;
    trap_kind_t            kind_q,   kind_d;
    logic [3:0]            cause_q,  cause_d;
    logic [DATA_WIDTH-1:0] pc_q,     pc_d;
    logic [DATA_WIDTH-1:0] mtvec_q,  mtvec_d;
    logic [DATA_WIDTH-1:0] mepc_q,   mepc_d;
    logic                  own_q,    own_d;
    logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
    logic                  wrbl_q,   wrbl_d;
    logic                  we1_q,    we1_d;
    logic                  we2_q,    we2_d;
    logic [ADDR_WIDTH-1:0] waddr1_q, waddr1_d;
    logic [ADDR_WIDTH-1:0] waddr2_q, waddr2_d;
    logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d;
    logic [DATA_WIDTH-1:0] wdata2_q, wdata2_d;
    logic                  ijump_q,  ijump_d;
    logic                  mret_q,   mret_d;
    logic                  busy_q,   busy_d;
    logic                  rvld_q,   rvld_d;
    logic [DATA_WIDTH-1:0] rpc_q,    rpc_d;
    logic [DATA_WIDTH-1:0] trap_base;
    logic [DATA_WIDTH-1:0] trap_target;

    // Vectored mode only offsets interrupts; the add wraps at DATA_WIDTH.
    always_comb begin
        trap_base   = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
        trap_target = trap_base;
        if (mtvec_q[1:0] == 2'b01 && kind_q == KIND_INT)
            trap_target = trap_base + DATA_WIDTH'({cause_q, 2'b00});
    end

    // Next state and captures, then outputs decoded from the next state so they register in step.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        own_d    = 1'b0;
        raddr_d  = '0;
        wrbl_d   = 1'b0;
        we1_d    = 1'b0;
        we2_d    = 1'b0;
        waddr1_d = '0;
        waddr2_d = '0;
        wdata1_d = '0;
        wdata2_d = '0;
        ijump_d  = 1'b0;
        mret_d   = 1'b0;
        rvld_d   = 1'b0;
        rpc_d    = rpc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    kind_d  = kind_c;
                    cause_d = cause_c;
                    pc_d    = i_pc;
                    state_d = (kind_c == KIND_RET) ? ST_RET_RD : ST_TRAP_RD;
                end
            end
            ST_TRAP_RD: begin
                mtvec_d = csr.i_csr_read_data;
                state_d = ST_TRAP_WR;
            end
            ST_TRAP_WR:  state_d = ST_REDIRECT;
            ST_RET_RD: begin
                mepc_d  = csr.i_csr_read_data;
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_TRAP_RD: begin
                own_d   = 1'b1;
                raddr_d = ADDR_WIDTH'(CSR_MTVEC);
                wrbl_d  = 1'b1;
            end
            ST_TRAP_WR: begin
                own_d    = 1'b1;
                we1_d    = 1'b1;
                we2_d    = 1'b1;
                waddr1_d = ADDR_WIDTH'(CSR_MEPC);
                waddr2_d = ADDR_WIDTH'(CSR_MCAUSE);
                wdata1_d = pc_q;
                wdata2_d = {kind_q == KIND_INT, (DATA_WIDTH-1-CAUSE_W)'(0), cause_q};
                ijump_d  = 1'b1;
            end
            ST_RET_RD: begin
                own_d   = 1'b1;
                raddr_d = ADDR_WIDTH'(CSR_MEPC);
                wrbl_d  = 1'b1;
                mret_d  = 1'b1;
            end
            ST_REDIRECT: begin
                rvld_d = 1'b1;
                rpc_d  = (kind_q == KIND_RET) ? {csr.i_csr_read_data[DATA_WIDTH-1:2], 2'b00}
                                              : trap_target;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            kind_q   <= KIND_NONE;
            cause_q  <= '0;
            pc_q     <= '0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            own_q    <= 1'b0;
            raddr_q  <= '0;
            wrbl_q   <= 1'b0;
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
            ijump_q  <= 1'b0;
            mret_q   <= 1'b0;
            busy_q   <= 1'b0;
            rvld_q   <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            own_q    <= own_d;
            raddr_q  <= raddr_d;
            wrbl_q   <= wrbl_d;
            we1_q    <= we1_d;
            we2_q    <= we2_d;
            waddr1_q <= waddr1_d;
            waddr2_q <= waddr2_d;
            wdata1_q <= wdata1_d;
            wdata2_q <= wdata2_d;
            ijump_q  <= ijump_d;
            mret_q   <= mret_d;
            busy_q   <= busy_d;
            rvld_q   <= rvld_d;
            rpc_q    <= rpc_d;
        end
    end

    assign csr.o_csr_own        = own_q;
    assign csr.o_csr_read_addr  = raddr_q;
    assign csr.o_csr_writable   = wrbl_q;
    assign csr.o_csr_we_1       = we1_q;
    assign csr.o_csr_we_2       = we2_q;
    assign csr.o_csr_waddr_1    = waddr1_q;
    assign csr.o_csr_waddr_2    = waddr2_q;
    assign csr.o_csr_wdata_1    = wdata1_q;
    assign csr.o_csr_wdata_2    = wdata2_q;
    assign csr.o_interrupt_jump = ijump_q;
    assign csr.o_mret_instr     = mret_q;
    assign o_busy               = busy_q;
    assign o_redirect_valid     = rvld_q;
    assign o_redirect_pc        = rpc_q;
endmodule
